// File: rtl/mont_encode.sv
// mont_encode: bit-serial encoder into the Montgomery domain, result = a * 2^N mod m
//   clk      in  1  clock, rising edge
//   reset    in  1  synchronous, active-high reset
//   start_i  in  1  start request, sampled only while idle
//   a_i      in  W  operand (a < 2m), sampled one cycle after start
//   m_i      in  W  modulus (0 < m < 2^(W-2)), sampled with a_i
//   result_o out W  a * 2^N mod m, held until the next completion
//   done_o   out 1  completion / idle flag
module mont_encode #(
    parameter int N = 256,
    parameter int W = 260
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] result_o,
    output logic         done_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PRE    = 3'd2;
    localparam logic [2:0] S_ITER   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    logic [2:0]   state_q, state_d;
    logic [W-1:0] a_q, a_d, m_q, m_d, acc_q, acc_d, result_q, result_d, t;
    logic [31:0]  cnt_q, cnt_d;
    logic         done_q, done_d;
    always_comb begin
        // acc < m < 2^(W-2), so the doubling never loses the top bit
        t        = acc_q << 1;
        state_d  = state_q;
        a_d      = a_q;
        m_d      = m_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE: begin
                state_d = start_i ? S_LOAD : S_IDLE;
                done_d  = !start_i;
            end
            S_LOAD: begin
                a_d     = a_i;
                m_d     = m_i;
                state_d = S_PRE;
            end
            S_PRE: begin
                acc_d   = (a_q >= m_q) ? a_q - m_q : a_q;
                cnt_d   = 32'(N);
                state_d = S_ITER;
            end
            S_ITER: begin
                acc_d   = (cnt_q != 32'd0) ? ((t >= m_q) ? t - m_q : t) : acc_q;
                cnt_d   = (cnt_q != 32'd0) ? cnt_q - 32'd1 : cnt_q;
                state_d = (cnt_q != 32'd0) ? S_ITER : S_FINISH;
            end
            S_FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end
    assign result_o = result_q;
    assign done_o   = done_q;
endmodule

// File: tb/tb_mont_encode.sv
// tb_mont_encode: self-checking bench for mont_encode
module tb_mont_encode;
    localparam int N = 256;
    localparam int W = 260;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] m;
        logic [W-1:0] exp;
    } vec_t;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] m_i = '0;
    logic [W-1:0] result_o;
    logic         done_o;
    logic [W-1:0] sb[$];
    int           errors = 0;
    int           checks = 0;
    always #5 clk = ~clk;
    mont_encode #(.N(N), .W(W)) dut (
        .clk(clk),
        .reset(reset),
        .start_i(start_i),
        .a_i(a_i),
        .m_i(m_i),
        .result_o(result_o),
        .done_o(done_o)
    );
    function automatic logic [W-1:0] enc_ref(input logic [W-1:0] a, input logic [W-1:0] m);
        logic [W+N-1:0] p;
        logic [W+N-1:0] q;
        p = {a, {N{1'b0}}};
        q = {{N{1'b0}}, m};
        p = p % q;
        return p[W-1:0];
    endfunction
    // Montgomery product y * 1 * 2^-N mod m, as the paired multiplier computes it
    function automatic logic [W-1:0] mul1_ref(input logic [W-1:0] y, input logic [W-1:0] m);
        logic [W:0] r;
        r = {1'b0, y};
        for (int i = 0; i < N; i++) begin
            if (r[0]) r = r + {1'b0, m};
            r = r >> 1;
        end
        if (r >= {1'b0, m}) r = r - {1'b0, m};
        return r[W-1:0];
    endfunction
    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] m, input logic [W-1:0] exp);
        @(negedge clk);
        a_i = a;
        m_i = m;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        sb.push_back(exp);
    endtask
    task automatic wait_done(input string nm, input int n0);
        int n;
        logic [W-1:0] exp;
        n = n0;
        while (!done_o && n < 400) begin
            tick();
            n++;
        end
        check({nm, "_latency"}, W'(n), W'(N + 4));
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        check(nm, result_o, exp);
    endtask
    initial begin
        vec_t         tbl[8];
        logic [W-1:0] bb_a[3];
        logic [W-1:0] bb_e[3];
        logic [W-1:0] mr;
        logic [W-1:0] xr;
        tbl[0] = '{a: 260'd1,  m: 260'd13, exp: 260'd3};
        tbl[1] = '{a: 260'd5,  m: 260'd13, exp: 260'd2};
        tbl[2] = '{a: 260'd12, m: 260'd13, exp: 260'd10};
        tbl[3] = '{a: 260'd15, m: 260'd13, exp: 260'd6};
        tbl[4] = '{a: 260'd0,  m: 260'd13, exp: 260'd0};
        tbl[5] = '{a: 260'd3,  m: 260'd7,  exp: 260'd6};
        tbl[6] = '{a: 260'd1,  m: 260'd1,  exp: 260'd0};
        tbl[7] = '{a: 260'd3,  m: 260'd10, exp: 260'd8};
        bb_a[0] = 260'd1;  bb_e[0] = 260'd3;
        bb_a[1] = 260'd5;  bb_e[1] = 260'd2;
        bb_a[2] = 260'd12; bb_e[2] = 260'd10;
        reset = 1'b1;
        repeat (3) begin
            tick();
            check("reset_result", result_o, '0);
            check("reset_done", W'(done_o), '0);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("idle_done_rise", W'(done_o), W'(1));
        tick();
        check("idle_done_hold", W'(done_o), W'(1));
        for (int i = 0; i < 8; i++) begin
            launch(tbl[i].a, tbl[i].m, tbl[i].exp);
            wait_done($sformatf("vec%0d", i), 0);
        end
        launch(260'd5, 260'd13, 260'd2);
        repeat (50) tick();
        @(negedge clk);
        a_i = 260'd1;
        m_i = 260'd7;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done("busy_isolation", 51);
        launch(260'd12, 260'd13, 260'd10);
        repeat (99) tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("midreset_result", result_o, '0);
        check("midreset_done", W'(done_o), '0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        launch(260'd1, 260'd13, 260'd3);
        wait_done("after_reset", 0);
        launch(260'd9, 260'd13, 260'd1);
        wait_done("rt13_enc", 0);
        check("rt13_roundtrip", mul1_ref(result_o, 260'd13), 260'd9);
        mr = '0;
        xr = '0;
        for (int i = 0; i < 8; i++) begin
            mr[i*32 +: 32] = $urandom;
            xr[i*32 +: 32] = $urandom;
        end
        mr[W-1:255] = '0;
        mr[254] = 1'b1;
        mr[0] = 1'b1;
        xr = xr % mr;
        launch(xr, mr, enc_ref(xr, mr));
        wait_done("rtrand_enc", 0);
        check("rtrand_roundtrip", mul1_ref(result_o, mr), xr);
        @(negedge clk);
        a_i = bb_a[0];
        m_i = 260'd13;
        start_i = 1'b1;
        tick();
        sb.push_back(bb_e[0]);
        for (int k = 0; k < 3; k++) begin
            wait_done($sformatf("b2b%0d", k), 0);
            if (k < 2) begin
                a_i = bb_a[k+1];
                sb.push_back(bb_e[k+1]);
                tick();
                check($sformatf("b2b_pulse%0d", k), W'(done_o), '0);
            end else begin
                start_i = 1'b0;
            end
        end
        repeat (2) tick();
        check("final_idle_done", W'(done_o), W'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
